// File: rtl/lcd_char_sched.sv
// Character scheduler for an HD44780-style LCD writer: two requesters are
// round-robin arbitrated into a FIFO, and an output FSM expands newlines into line padding.
module lcd_char_sched #(
    parameter int         DEPTH    = 8,
    parameter int         LINE_LEN = 16,
    parameter logic [7:0] NL_CHAR  = 8'h0A,
    parameter logic [7:0] PAD_CHAR = 8'h20
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic [4:0] fifo_count,
    output logic [3:0] col
);
    // state | meaning
    // IDLE  | output register empty; pops the FIFO head when one has settled
    // SEND  | holding a printable character until the writer accepts it
    // PAD   | emitting PAD_CHAR up to the end of the current line

    localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL_COUNT = 5'(DEPTH);
    localparam logic [3:0] LAST_COL   = 4'(LINE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        PAD  = 2'd2
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          last_grant;
    logic          settled;
    logic          has_space;
    logic          grant1;
    logic          push;
    logic          pop;
    logic [7:0]    push_data;
    logic [7:0]    head;

    // last_grant = 1 means requester 1 was served last, so requester 0 wins a tie.
    assign has_space  = fifo_count < FULL_COUNT;
    assign grant1     = req1_valid && (!req0_valid || !last_grant);
    assign req0_ready = has_space && req0_valid && !grant1;
    assign req1_ready = has_space && grant1;
    assign push       = req0_ready || req1_ready;
    assign push_data  = grant1 ? req1_data : req0_data;
    assign head       = mem[rd_ptr];

    // An entry must have been resident for a full cycle before it is popped,
    // which sets the two-edge push-to-output latency.
    assign pop = (state == IDLE) && settled && (fifo_count != 5'd0);

    always_ff @(posedge clk50) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            last_grant <= 1'b1;
            settled    <= 1'b0;
        end else begin
            settled <= (fifo_count != 5'd0);
            if (push) begin
                wr_ptr     <= wr_ptr + AW'(1);
                last_grant <= grant1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 5'd1;
                2'b01:   fifo_count <= fifo_count - 5'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            col       <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head != NL_CHAR) begin
                            out_data  <= head;
                            out_valid <= 1'b1;
                            state     <= SEND;
                        end else if (col != 4'd0) begin
                            out_data  <= PAD_CHAR;
                            out_valid <= 1'b1;
                            state     <= PAD;
                        end
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        col       <= (col == LAST_COL) ? 4'd0 : col + 4'd1;
                        state     <= IDLE;
                    end
                end
                PAD: begin
                    if (out_ready) begin
                        if (col == LAST_COL) begin
                            col       <= 4'd0;
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            col <= col + 4'd1;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_char_sched.sv
// Bench for lcd_char_sched: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_lcd_char_sched;
    localparam int         DEPTH    = 8;
    localparam int         LINE_LEN = 16;
    localparam logic [7:0] NL       = 8'h0A;
    localparam logic [7:0] PADC     = 8'h20;

    typedef logic [7:0] byte_q_t [$];
    typedef logic [3:0] col_q_t [$];

    typedef struct {
        logic       r0v;
        logic [7:0] r0d;
        logic       r1v;
        logic [7:0] r1d;
        logic       ordy;
        logic       e_r0rdy;
        logic       e_r1rdy;
        logic       e_ov;
        logic [7:0] e_od;
        logic [4:0] e_cnt;
        logic [3:0] e_col;
    } vec_t;

    logic       clk50      = 1'b0;
    logic       reset      = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data  = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data  = 8'h00;
    logic       req1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready  = 1'b0;
    logic [4:0] fifo_count;
    logic [3:0] col;

    int tests = 0;
    int fails = 0;
    vec_t vecs [12];

    lcd_char_sched #(
        .DEPTH(DEPTH), .LINE_LEN(LINE_LEN), .NL_CHAR(NL), .PAD_CHAR(PADC)
    ) dut (
        .clk50(clk50), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .fifo_count(fifo_count), .col(col)
    );

    always #5 clk50 = ~clk50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req0_data  = 8'h00;
        req1_valid = 1'b0;
        req1_data  = 8'h00;
        out_ready  = 1'b0;
        reset      = 1'b0;
        repeat (2) @(posedge clk50);
        #1;
        reset = 1'b1;
    endtask

    // Feeds chars through requester 0 for ncyc cycles, recording accepted outputs
    // and the column value right after each acceptance.
    task automatic feed(input byte_q_t chars, input logic ordy, input int ncyc,
                        output byte_q_t got, output col_q_t cols);
        int   i = 0;
        logic acc_in;
        logic acc_out;
        got       = {};
        cols      = {};
        out_ready = ordy;
        for (int c = 0; c < ncyc; c++) begin
            req0_valid = (i < chars.size());
            req0_data  = (i < chars.size()) ? chars[i] : 8'h00;
            @(negedge clk50);
            acc_in  = req0_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) got.push_back(out_data);
            @(posedge clk50);
            #1;
            if (acc_in) i++;
            if (acc_out) cols.push_back(col);
        end
        req0_valid = 1'b0;
        req0_data  = 8'h00;
    endtask

    task automatic test_table();
        for (int i = 0; i < 12; i++) begin
            req0_valid = vecs[i].r0v;
            req0_data  = vecs[i].r0d;
            req1_valid = vecs[i].r1v;
            req1_data  = vecs[i].r1d;
            out_ready  = vecs[i].ordy;
            @(negedge clk50);
            check($sformatf("vec%0d_req0_ready", i), 32'(req0_ready), 32'(vecs[i].e_r0rdy));
            check($sformatf("vec%0d_req1_ready", i), 32'(req1_ready), 32'(vecs[i].e_r1rdy));
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov)
                check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
            check($sformatf("vec%0d_fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
            check($sformatf("vec%0d_col", i), 32'(col), 32'(vecs[i].e_col));
            @(posedge clk50);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_contention();
        int         ia = 0;
        int         ib = 0;
        logic       r0;
        logic       r1;
        logic [7:0] got [$];
        logic [7:0] exp;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            req0_valid = (ia < 4);
            req0_data  = 8'hA0 + 8'(ia);
            req1_valid = (ib < 4);
            req1_data  = 8'hB0 + 8'(ib);
            @(negedge clk50);
            r0 = req0_ready;
            r1 = req1_ready;
            if (out_valid) got.push_back(out_data);
            @(posedge clk50);
            #1;
            if (r0) ia++;
            if (r1) ib++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("contention_count", 32'(got.size()), 32'd8);
        for (int k = 0; k < got.size() && k < 8; k++) begin
            exp = ((k % 2) == 0) ? 8'hA0 + 8'(k / 2) : 8'hB0 + 8'(k / 2);
            check($sformatf("contention_order%0d", k), 32'(got[k]), 32'(exp));
        end
    endtask

    task automatic test_backpressure();
        int      idx = 0;
        logic    r;
        byte_q_t none;
        byte_q_t got;
        col_q_t  cols;
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            req0_valid = (idx < 10);
            req0_data  = 8'h30 + 8'(idx);
            @(negedge clk50);
            r = req0_ready;
            @(posedge clk50);
            #1;
            if (r) idx++;
        end
        @(negedge clk50);
        check("bp_accepted", 32'(idx), 32'd9);
        check("bp_fifo_full", 32'(fifo_count), 32'd8);
        check("bp_ready_low", 32'(req0_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_out_held", 32'(out_data), 32'h30);
        @(posedge clk50);
        #1;
        none = {};
        feed(none, 1'b1, 40, got, cols);
        check("bp_delivered", 32'(got.size()), 32'd9);
        for (int k = 0; k < got.size() && k < 9; k++)
            check($sformatf("bp_order%0d", k), 32'(got[k]), 32'(8'h30 + 8'(k)));
        check("bp_fifo_empty", 32'(fifo_count), 32'd0);
    endtask

    task automatic test_newline();
        byte_q_t chars;
        byte_q_t got;
        col_q_t  cols;
        do_reset();
        chars = {};
        chars.push_back(8'h48);
        chars.push_back(8'h49);
        chars.push_back(NL);
        feed(chars, 1'b1, 50, got, cols);
        check("nl_count", 32'(got.size()), 32'd16);
        for (int k = 0; k < got.size() && k < 16; k++)
            check($sformatf("nl_byte%0d", k), 32'(got[k]),
                  32'((k == 0) ? 8'h48 : (k == 1) ? 8'h49 : PADC));
        check("nl_col_end", 32'(col), 32'd0);
        chars = {};
        chars.push_back(NL);
        feed(chars, 1'b1, 15, got, cols);
        check("nl_drop_count", 32'(got.size()), 32'd0);
        check("nl_drop_col", 32'(col), 32'd0);
        check("nl_drop_fifo", 32'(fifo_count), 32'd0);
    endtask

    task automatic test_wrap();
        byte_q_t chars;
        byte_q_t got;
        col_q_t  cols;
        do_reset();
        chars = {};
        for (int k = 0; k < 17; k++) chars.push_back(8'h61 + 8'(k));
        feed(chars, 1'b1, 80, got, cols);
        check("wrap_count", 32'(cols.size()), 32'd17);
        if (cols.size() == 17) begin
            check("wrap_col15", 32'(cols[14]), 32'd15);
            check("wrap_col16", 32'(cols[15]), 32'd0);
            check("wrap_col17", 32'(cols[16]), 32'd1);
            check("wrap_last_char", 32'(got[16]), 32'h71);
        end
    endtask

    task automatic test_async_reset();
        byte_q_t chars;
        byte_q_t got;
        col_q_t  cols;
        do_reset();
        chars = {};
        chars.push_back(8'h41);
        feed(chars, 1'b1, 10, got, cols);
        chars = {};
        chars.push_back(NL);
        chars.push_back(8'h58);
        chars.push_back(8'h59);
        feed(chars, 1'b0, 8, got, cols);
        check("ar_pad_valid", 32'(out_valid), 32'd1);
        check("ar_pad_data", 32'(out_data), 32'(PADC));
        check("ar_pad_fifo", 32'(fifo_count), 32'd2);
        check("ar_pad_col", 32'(col), 32'd1);
        @(negedge clk50);
        #2;
        reset = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_out_data", 32'(out_data), 32'd0);
        check("ar_col", 32'(col), 32'd0);
        check("ar_fifo", 32'(fifo_count), 32'd0);
        @(posedge clk50);
        #1;
        reset = 1'b1;
        chars = {};
        chars.push_back(8'h5A);
        feed(chars, 1'b1, 20, got, cols);
        check("ar_resume_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) check("ar_resume_data", 32'(got[0]), 32'h5A);
        check("ar_resume_col", 32'(col), 32'd1);
    endtask

    // Reference model: FIFO as a queue, each popped character expanded into the
    // list of bytes it produces on the LCD; one output byte retires per accept.
    task automatic test_random();
        logic [7:0] fq [$];
        logic [7:0] oq [$];
        int         mcol = 0;
        int         prev_cnt = 0;
        int         cnt;
        int         winner;
        logic       mlast = 1'b1;
        logic       idle;
        logic [7:0] h;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req0_data  = ($urandom_range(0, 5) == 0) ? NL : 8'($urandom_range(0, 255));
            req1_valid = 1'($urandom_range(0, 1));
            req1_data  = ($urandom_range(0, 5) == 0) ? NL : 8'($urandom_range(0, 255));
            out_ready  = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            @(negedge clk50);
            cnt    = fq.size();
            winner = -1;
            if (req0_valid && req1_valid) winner = mlast ? 0 : 1;
            else if (req0_valid)          winner = 0;
            else if (req1_valid)          winner = 1;
            if (cnt >= DEPTH) winner = -1;
            check("rnd_req0_ready", 32'(req0_ready), 32'(winner == 0));
            check("rnd_req1_ready", 32'(req1_ready), 32'(winner == 1));
            check("rnd_out_valid", 32'(out_valid), 32'(oq.size() != 0));
            if (oq.size() != 0) check("rnd_out_data", 32'(out_data), 32'(oq[0]));
            check("rnd_fifo_count", 32'(fifo_count), 32'(cnt));
            check("rnd_col", 32'(col), 32'(mcol));
            @(posedge clk50);
            idle = (oq.size() == 0);
            if (!idle && out_ready) begin
                void'(oq.pop_front());
                mcol = (mcol + 1) % LINE_LEN;
            end
            if (idle && cnt > 0 && prev_cnt > 0) begin
                h = fq.pop_front();
                if (h != NL) oq.push_back(h);
                else if (mcol != 0)
                    for (int k = 0; k < LINE_LEN - mcol; k++) oq.push_back(PADC);
            end
            if (winner >= 0) begin
                fq.push_back((winner == 1) ? req1_data : req0_data);
                mlast = (winner == 1);
            end
            prev_cnt = cnt;
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        vecs = '{
            '{1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 4'd0},
            '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 4'd0},
            '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 4'd0},
            '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41, 5'd0, 4'd0},
            '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 4'd1},
            '{1'b0, 8'h00, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 4'd1},
            '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 4'd1},
            '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 4'd1},
            '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42, 5'd0, 4'd1},
            '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h42, 5'd0, 4'd1},
            '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 4'd2},
            '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 4'd2}
        };
        #1;
        reset = 1'b0;
        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_fifo_count", 32'(fifo_count), 32'd0);
        check("reset_col", 32'(col), 32'd0);
        repeat (2) @(posedge clk50);
        #1;
        reset = 1'b1;

        test_table();
        test_contention();
        test_backpressure();
        test_newline();
        test_wrap();
        test_async_reset();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
